// File: rtl/user_timer_ctrl.sv
// User-domain timer: OBI register slave wrapped around a prescaled counter
// with a compare match, one-shot/periodic modes and a level interrupt.
module user_timer_ctrl #(
  parameter int CntWidth = 32,
  parameter int PscWidth = 16,
  parameter int IdWidth  = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_i,
  output logic               gnt_o,
  input  logic [31:0]        addr_i,
  input  logic               we_i,
  input  logic [3:0]         be_i,
  input  logic [31:0]        wdata_i,
  input  logic [IdWidth-1:0] aid_i,
  output logic               rvalid_o,
  output logic [31:0]        rdata_o,
  output logic [IdWidth-1:0] rid_o,
  output logic               err_o,
  output logic               irq_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [9:0] OffCtrl     = 10'd0;
  localparam logic [9:0] OffPrescale = 10'd1;
  localparam logic [9:0] OffCount    = 10'd2;
  localparam logic [9:0] OffCompare  = 10'd3;
  localparam logic [9:0] OffStatus   = 10'd4;

  state_e                state_q, state_d;
  logic                  en_q, en_d;
  logic                  mode_q, mode_d;
  logic                  irqen_q, irqen_d;
  logic                  match_q, match_d;
  logic [PscWidth-1:0]   psc_reg_q, psc_reg_d;
  logic [PscWidth-1:0]   psc_cnt_q, psc_cnt_d;
  logic [CntWidth-1:0]   count_q, count_d;
  logic [CntWidth-1:0]   compare_q, compare_d;
  logic                  rvalid_q, rvalid_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [IdWidth-1:0]    rid_q, rid_d;
  logic                  err_q, err_d;

  logic [9:0] word_off;
  logic       addr_ok;
  logic       wr_en;
  logic       rd_en;
  logic       active;
  logic       tick;
  logic       hit;
  logic       status_clr;
  logic       unused_addr;

  // Only the 4 KiB window offset is decoded; the window base is resolved upstream.
  assign unused_addr = ^addr_i[31:12];
  assign word_off    = addr_i[11:2];
  assign addr_ok     = (addr_i[1:0] == 2'b00) && (word_off <= OffStatus);
  assign wr_en       = req_i & we_i & addr_ok;
  assign rd_en       = req_i & ~we_i & addr_ok;

  // The counter only advances while running with EN still set, so a stop takes effect at once.
  assign active     = (state_q == ST_RUN) && en_q;
  assign tick       = active && (psc_cnt_q == psc_reg_q);
  assign hit        = tick && (count_q == compare_q);
  assign status_clr = wr_en && (word_off == OffStatus) && be_i[0] && wdata_i[0];

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

  // Next-state logic: follow EN, and drop back to idle after a one-shot match.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en_q) state_d = ST_RUN;
      ST_RUN:  if (!en_q || (hit && !mode_q)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Timer datapath and register writes; software writes are applied last so they win.
  always_comb begin
    en_d      = en_q;
    mode_d    = mode_q;
    irqen_d   = irqen_q;
    psc_reg_d = psc_reg_q;
    compare_d = compare_q;
    count_d   = count_q;
    psc_cnt_d = '0;
    match_d   = match_q & ~status_clr;

    if (active) begin
      psc_cnt_d = tick ? '0 : psc_cnt_q + PscWidth'(1);
    end

    if (tick) begin
      if (hit) begin
        match_d = 1'b1;
        if (mode_q) count_d = '0;
        else        en_d    = 1'b0;
      end else begin
        count_d = count_q + CntWidth'(1);
      end
    end

    if (wr_en) begin
      case (word_off)
        OffCtrl: begin
          if (be_i[0]) begin
            en_d    = wdata_i[0];
            mode_d  = wdata_i[1];
            irqen_d = wdata_i[2];
          end
        end
        OffPrescale: begin
          psc_reg_d = PscWidth'(merge_bytes(32'(psc_reg_q), wdata_i, be_i));
          psc_cnt_d = '0;
        end
        OffCount:   count_d   = CntWidth'(merge_bytes(32'(count_q), wdata_i, be_i));
        OffCompare: compare_d = CntWidth'(merge_bytes(32'(compare_q), wdata_i, be_i));
        default: ;
      endcase
    end
  end

  // Bus response for the request seen this cycle, presented on the next cycle.
  always_comb begin
    rvalid_d = req_i;
    rid_d    = aid_i;
    rdata_d  = '0;
    err_d    = 1'b0;
    if (req_i && !addr_ok) begin
      err_d = 1'b1;
    end else if (rd_en) begin
      case (word_off)
        OffCtrl:     rdata_d = {29'd0, irqen_q, mode_q, en_q};
        OffPrescale: rdata_d = 32'(psc_reg_q);
        OffCount:    rdata_d = 32'(count_q);
        OffCompare:  rdata_d = 32'(compare_q);
        OffStatus:   rdata_d = {30'd0, (state_q == ST_RUN), match_q};
        default:     rdata_d = '0;
      endcase
    end
  end

  // All state, including any pending response, is cleared by the synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      en_q      <= 1'b0;
      mode_q    <= 1'b0;
      irqen_q   <= 1'b0;
      match_q   <= 1'b0;
      psc_reg_q <= '0;
      psc_cnt_q <= '0;
      count_q   <= '0;
      compare_q <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rid_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      mode_q    <= mode_d;
      irqen_q   <= irqen_d;
      match_q   <= match_d;
      psc_reg_q <= psc_reg_d;
      psc_cnt_q <= psc_cnt_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rid_q     <= rid_d;
      err_q     <= err_d;
    end
  end

  assign gnt_o    = 1'b1;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign rid_o    = rid_q;
  assign err_o    = err_q;
  assign irq_o    = match_q & irqen_q;

endmodule

// File: tb/tb_user_timer_ctrl.sv
// Self-checking bench for user_timer_ctrl: a register-level timer model is
// compared against the DUT every cycle, plus hand-computed directed checks.
module tb_user_timer_ctrl;

  localparam logic [31:0] ACtrl     = 32'h2000_1000;
  localparam logic [31:0] APrescale = 32'h2000_1004;
  localparam logic [31:0] ACount    = 32'h2000_1008;
  localparam logic [31:0] ACompare  = 32'h2000_100C;
  localparam logic [31:0] AStatus   = 32'h2000_1010;

  logic        clk;
  logic        rst;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        aid;
  logic        rvalid;
  logic [31:0] rdata;
  logic        rid;
  logic        err;
  logic        irq;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  user_timer_ctrl #(.CntWidth(32), .PscWidth(16), .IdWidth(1)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req),
    .gnt_o   (gnt),
    .addr_i  (addr),
    .we_i    (we),
    .be_i    (be),
    .wdata_i (wdata),
    .aid_i   (aid),
    .rvalid_o(rvalid),
    .rdata_o (rdata),
    .rid_o   (rid),
    .err_o   (err),
    .irq_o   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: the programmer-visible registers plus the prescaler phase.
  logic [31:0] m_cnt, m_cmp, m_rv;
  logic [15:0] m_psc;
  int          m_phase, m_off;
  bit          m_en, m_mode, m_irqen, m_match, m_run;
  bit          m_ok, m_tick, m_hit, m_nrun;
  logic        e_rvalid, e_err, e_rid;
  logic [31:0] e_rdata;
  bit          model_live = 1'b0;

  function automatic logic [31:0] mergeBytes(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (b[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  // Model one clock: answer the bus, advance the timer, then apply software writes.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_cnt = '0; m_cmp = '0; m_psc = '0; m_phase = 0;
      m_en = 0; m_mode = 0; m_irqen = 0; m_match = 0; m_run = 0;
      e_rvalid = 0; e_err = 0; e_rid = 0; e_rdata = '0;
      model_live = 1'b1;
    end else begin
      m_off = int'(addr[11:2]);
      m_ok  = (addr[1:0] == 2'b00) && (m_off <= 4);
      case (m_off)
        0:       m_rv = {29'd0, m_irqen, m_mode, m_en};
        1:       m_rv = {16'd0, m_psc};
        2:       m_rv = m_cnt;
        3:       m_rv = m_cmp;
        4:       m_rv = {30'd0, m_run, m_match};
        default: m_rv = '0;
      endcase
      e_rvalid = req;
      e_rid    = aid;
      e_err    = req && !m_ok;
      e_rdata  = (req && !we && m_ok) ? m_rv : 32'd0;

      m_tick = m_run && m_en && (m_phase == int'(m_psc));
      m_hit  = m_tick && (m_cnt == m_cmp);
      m_nrun = m_run ? (m_en && !(m_hit && !m_mode)) : m_en;
      m_phase = (m_run && m_en && !m_tick) ? m_phase + 1 : 0;

      if (req && we && m_ok && m_off == 4 && be[0] && wdata[0]) m_match = 0;
      if (m_hit) begin
        m_match = 1;
        if (m_mode) m_cnt = '0;
        else        m_en  = 0;
      end else if (m_tick) begin
        m_cnt = m_cnt + 32'd1;
      end

      if (req && we && m_ok) begin
        case (m_off)
          0: if (be[0]) begin m_en = wdata[0]; m_mode = wdata[1]; m_irqen = wdata[2]; end
          1: begin m_psc = mergeBytes({16'd0, m_psc}, wdata, be) & 32'h0000_FFFF; m_phase = 0; end
          2: m_cnt = mergeBytes(m_cnt, wdata, be);
          3: m_cmp = mergeBytes(m_cmp, wdata, be);
          default: ;
        endcase
      end
      m_run = m_nrun;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model, away from the clock edge.
  always @(negedge clk) begin
    if (model_live) begin
      checkOutput("gnt",    32'(gnt),    32'd1);
      checkOutput("rvalid", 32'(rvalid), 32'(e_rvalid));
      checkOutput("err",    32'(err),    32'(e_err));
      checkOutput("rdata",  rdata,       e_rdata);
      checkOutput("irq",    32'(irq),    32'(m_match & m_irqen));
      if (e_rvalid) checkOutput("rid", 32'(rid), 32'(e_rid));
    end
  end

  // One bus request for a single cycle; returns in the response cycle.
  task automatic applyStimulus(input bit w, input logic [31:0] a, input logic [3:0] b,
                               input logic [31:0] d, input logic id);
    @(posedge clk); #1;
    req = 1'b1; we = w; addr = a; be = b; wdata = d; aid = id;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0; aid = 1'b0;
  endtask

  task automatic writeReg(input logic [31:0] a, input logic [31:0] d);
    applyStimulus(1'b1, a, 4'hF, d, 1'b0);
  endtask

  task automatic readCheck(input string name, input logic [31:0] a, input logic [31:0] exp);
    applyStimulus(1'b0, a, 4'hF, 32'd0, 1'b0);
    checkOutput({name, "_rvalid"}, 32'(rvalid), 32'd1);
    checkOutput(name, rdata, exp);
  endtask

  task automatic waitIrq(output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 200) begin
      @(negedge clk);
      if (irq === 1'b1) seen = 1'b1;
      else n++;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL irq_timeout: irq still low after %0d cycles, expected high", n);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  int n, t1, t2;

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0; aid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    $display("[TB] reset checks");
    checkOutput("reset_irq", 32'(irq), 32'd0);
    readCheck("reset_ctrl",   ACtrl,   32'd0);
    readCheck("reset_count",  ACount,  32'd0);
    readCheck("reset_status", AStatus, 32'd0);

    // Periodic, prescale 3, compare 5: 6 ticks of 4 cycles
    $display("[TB] periodic prescaled match");
    writeReg(APrescale, 32'd3);
    writeReg(ACompare,  32'd5);
    writeReg(ACtrl,     32'h7);
    waitIrq(n);
    checkOutput("periodic_latency", n, 32'd25);
    t1 = cyc;
    applyStimulus(1'b1, AStatus, 4'h1, 32'h1, 1'b0);
    checkOutput("w1c_irq_drop", 32'(irq), 32'd0);
    readCheck("periodic_count_zero", ACount, 32'd0);
    waitIrq(n);
    t2 = cyc;
    checkOutput("periodic_interval", t2 - t1, 32'd24);
    writeReg(ACtrl, 32'h0);

    // One-shot, prescale 0, compare 2
    $display("[TB] one-shot match");
    applyStimulus(1'b1, AStatus, 4'h1, 32'h1, 1'b0);
    writeReg(ACount,    32'd0);
    writeReg(APrescale, 32'd0);
    writeReg(ACompare,  32'd2);
    writeReg(ACtrl,     32'h5);
    waitIrq(n);
    checkOutput("oneshot_latency", n, 32'd4);
    readCheck("oneshot_ctrl",   ACtrl,   32'h4);
    readCheck("oneshot_count",  ACount,  32'd2);
    readCheck("oneshot_status", AStatus, 32'h1);

    // Wrap through 2^32-1 -> 0 without a match, then match at 1
    $display("[TB] counter wrap");
    applyStimulus(1'b1, AStatus, 4'h1, 32'h1, 1'b0);
    writeReg(ACount,   32'hFFFF_FFFE);
    writeReg(ACompare, 32'd1);
    writeReg(ACtrl,    32'h7);
    waitIrq(n);
    checkOutput("wrap_latency", n, 32'd5);
    // This write lands on the next match tick, so MATCH must survive it
    applyStimulus(1'b1, AStatus, 4'h1, 32'h1, 1'b0);
    checkOutput("w1c_vs_match", 32'(irq), 32'd1);
    writeReg(ACtrl, 32'h0);

    // Error responses, back-to-back, id echo
    $display("[TB] unmapped and misaligned accesses");
    writeReg(32'h2000_1014, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 32'h2000_100D, 4'hF, 32'h0000_0055, 1'b0);
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; be = 4'hF; aid = 1'b1; addr = 32'h2000_1014;
    @(posedge clk); #1;
    addr = 32'h2000_1002;
    checkOutput("err14_err",   32'(err),   32'd1);
    checkOutput("err14_rid",   32'(rid),   32'd1);
    checkOutput("err14_rdata", rdata,      32'd0);
    @(posedge clk); #1;
    req = 1'b0; aid = 1'b0; addr = '0;
    checkOutput("err02_rvalid", 32'(rvalid), 32'd1);
    checkOutput("err02_err",    32'(err),    32'd1);
    checkOutput("err02_rid",    32'(rid),    32'd1);
    checkOutput("err02_rdata",  rdata,       32'd0);
    readCheck("err_compare_kept",  ACompare,  32'd1);
    readCheck("err_prescale_kept", APrescale, 32'd0);

    // Byte-enable write
    $display("[TB] byte enables");
    writeReg(ACount, 32'h1122_3344);
    applyStimulus(1'b1, ACount, 4'b0010, 32'hAABB_CCDD, 1'b0);
    readCheck("be_count", ACount, 32'h1122_CC44);

    // Reset while running, with a request in the reset cycle
    $display("[TB] reset mid-operation");
    writeReg(ACtrl, 32'h3);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1; req = 1'b1; we = 1'b0; addr = ACount; be = 4'hF;
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0; addr = '0; be = '0;
    checkOutput("reset_drop_rvalid", 32'(rvalid), 32'd0);
    readCheck("reset2_count", ACount, 32'd0);
    readCheck("reset2_ctrl",  ACtrl,  32'd0);
    checkOutput("reset2_irq", 32'(irq), 32'd0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
